load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter ROM_END, default 64000: first writable byte address; addresses below it are read-only.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  request present.
REQ-005 req_ready  output  1  unit can accept a request.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_size  input  2  0 byte, 1 halfword, 2 word, 3 reserved.
REQ-008 req_signed  input  1  sign-extend loaded byte/halfword.
REQ-009 req_addr  input  32  byte address.
REQ-010 req_wdata  input  32  store data, right-justified.
REQ-011 resp_valid  output  1  one-cycle completion pulse.
REQ-012 resp_rdata  output  32  load result, zero or sign extended; 0 for stores and faults.
REQ-013 resp_fault  output  1  request rejected, no memory access made.
REQ-014 mem_address  output  32  word-aligned address to memory.
REQ-015 mem_data_in  output  32  write data to memory.
REQ-016 mem_write  output  1  memory write strobe.
REQ-017 mem_data_out  input  32  memory read data, valid the cycle after mem_address is driven.

Function
REQ-018 States SHALL be IDLE, READ, MERGE, WRITE, RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 Accept occurs on a rising edge with req_valid && req_ready; all request fields SHALL be latched at accept; inputs are ignored otherwise.
REQ-020 Byte order SHALL be little-endian; lane = addr[1:0]; mem_address = {addr[31:2], 2'b00} in READ and WRITE, 0 elsewhere.
REQ-021 Fault conditions: size 3; halfword with addr[0]=1; word with addr[1:0]!=0; store with addr < ROM_END.
REQ-022 Fault: IDLE -> RESP; resp_valid and resp_fault high in cycle N+1 (N = accept cycle); no READ or WRITE state is entered.
REQ-023 Load: IDLE -> READ (N+1) -> MERGE (N+2, capture mem_data_out, extract lane) -> RESP (N+3).
REQ-024 Word store: IDLE -> WRITE (N+1, mem_data_in = wdata) -> RESP (N+2).
REQ-025 Byte/halfword store: IDLE -> READ -> MERGE (replace addressed lane(s) of read word with low bits of wdata, register) -> WRITE (N+3) -> RESP (N+4).
REQ-026 mem_write SHALL be 1 only in WRITE; mem_data_in SHALL be 0 outside WRITE.
REQ-027 RESP SHALL last exactly one cycle, then IDLE; resp_valid SHALL have no backpressure.
REQ-028 The earliest next accept is the cycle after RESP; back-to-back requests SHALL NOT overlap.

Reset
REQ-029 On reset assertion, the state SHALL go to IDLE asynchronously, mem_write SHALL drop to 0 in the same cycle, and any in-flight request SHALL be discarded without a response.
REQ-030 Reset values: req_ready 1 after release, resp_valid 0, resp_fault 0, resp_rdata 0, mem_address 0, mem_data_in 0, mem_write 0.

Structure
REQ-031 Package lsu_pkg SHALL hold the size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the state enum.
REQ-032 A combinational sub-module lsu_align SHALL perform lane extract/extend (load) and lane merge (store), with fault decode in the top module.

Verification
REQ-033 Word store 0xDEADBEEF at 0x10000, then word load at 0x10000 -> resp_rdata 0xDEADBEEF; store resp at N+2, load resp at N+3.
REQ-034 With word 0x11223344 at 0x10000, store byte 0xAA at 0x10002 -> memory word 0x11AA3344; signed byte load at 0x10002 -> 0xFFFFFFAA; unsigned -> 0x000000AA.
REQ-035 Halfword load at 0x10001 -> resp_fault 1 at N+1, mem_address stays 0, mem_write never high.
REQ-036 Word store to 0x00000100 (below ROM_END) -> fault, mem_write never asserted; store to 63999 (word-aligned 63996) also faults; store to 64000 succeeds.
REQ-037 Assert reset during the WRITE state of a byte store -> mem_write falls the same cycle, no resp_valid, req_ready 1 after release.
REQ-038 Hold req_valid high continuously with 3 word loads -> accepts only in IDLE cycles, responses spaced 4 cycles apart, in order.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: access sizes and controller states.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2,
        SIZE_RSVD = 2'd3
    } size_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        MERGE = 3'd2,
        WRITE = 3'd3,
        RESP  = 3'd4
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Little-endian lane handling: extract/extend a loaded lane, merge store data into a read word.
// Purely combinational.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rd_word,
    input  logic [1:0]  i_lane,
    input  size_e       i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged
);
    logic [4:0]  w_shift;
    logic [31:0] w_rd_shifted;
    logic [31:0] w_mask;
    logic [31:0] w_wdata_shifted;

    assign w_shift         = {i_lane, 3'b000};
    assign w_rd_shifted    = i_rd_word >> w_shift;
    assign w_wdata_shifted = i_wdata << w_shift;

    always_comb begin
        o_load_data = i_rd_word;
        w_mask      = 32'hFFFF_FFFF;
        case (i_size)
            SIZE_BYTE: begin
                o_load_data = {{24{i_signed & w_rd_shifted[7]}}, w_rd_shifted[7:0]};
                w_mask      = 32'h0000_00FF << w_shift;
            end
            SIZE_HALF: begin
                o_load_data = {{16{i_signed & w_rd_shifted[15]}}, w_rd_shifted[15:0]};
                w_mask      = 32'h0000_FFFF << w_shift;
            end
            default: begin
                o_load_data = i_rd_word;
                w_mask      = 32'hFFFF_FFFF;
            end
        endcase
    end

    // Only the addressed lane(s) take store data; the rest keep what memory held.
    assign o_merged = (i_rd_word & ~w_mask) | (w_wdata_shifted & w_mask);

endmodule

// File: rtl/load_store_unit.sv
// Byte/halfword/word load-store controller over a word-wide single-cycle-latency memory.
// Sub-word stores are read-modify-write; stores below ROM_END and misaligned accesses fault.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ROM_END = 64000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_write,
    input  logic [31:0] mem_data_out
);
    lsu_state_e  r_state;
    lsu_state_e  w_next;
    logic        r_write;
    size_e       r_size;
    logic        r_signed;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_fault;
    logic [31:0] r_rdata;

    logic        w_accept;
    logic        w_fault;
    logic [31:0] w_load_data;
    logic [31:0] w_merged;

    assign w_accept = (r_state == IDLE) && req_valid;

    assign w_fault = (req_size == SIZE_RSVD)
                   | ((req_size == SIZE_HALF) && req_addr[0])
                   | ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00))
                   | (req_write && (req_addr < ROM_END));

    lsu_align u_align (
        .i_rd_word   (mem_data_out),
        .i_lane      (r_addr[1:0]),
        .i_size      (r_size),
        .i_signed    (r_signed),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_write  <= 1'b0;
            r_size   <= SIZE_BYTE;
            r_signed <= 1'b0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
            r_fault  <= 1'b0;
            r_rdata  <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_write  <= req_write;
                r_size   <= size_e'(req_size);
                r_signed <= req_signed;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
                r_fault  <= w_fault;
                r_rdata  <= 32'h0;
            end else if (r_state == MERGE) begin
                // Stores reuse r_wdata to hold the merged word for the WRITE cycle.
                if (r_write) r_wdata <= w_merged;
                else         r_rdata <= w_load_data;
            end
        end
    end

    always_comb begin
        w_next      = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_fault  = 1'b0;
        resp_rdata  = 32'h0;
        mem_address = 32'h0;
        mem_data_in = 32'h0;
        mem_write   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_fault)                                   w_next = RESP;
                    else if (req_write && (req_size == SIZE_WORD)) w_next = WRITE;
                    else                                           w_next = READ;
                end
            end
            READ: begin
                mem_address = {r_addr[31:2], 2'b00};
                w_next      = MERGE;
            end
            MERGE: begin
                w_next = r_write ? WRITE : RESP;
            end
            WRITE: begin
                mem_address = {r_addr[31:2], 2'b00};
                mem_data_in = r_wdata;
                mem_write   = 1'b1;
                w_next      = RESP;
            end
            RESP: begin
                resp_valid = 1'b1;
                resp_fault = r_fault;
                resp_rdata = r_rdata;
                w_next     = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench: the driver queues expected responses, a negedge monitor checks them.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_fault, mem_write;
    logic [31:0] resp_rdata, mem_address, mem_data_in;
    logic [31:0] mem_data_out = 32'h0;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        int          cyc;
    } exp_t;

    exp_t        expq[$];
    int          resp_cyc[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          anz_cnt = 0;
    logic [31:0] mem [0:65535];

    load_store_unit #(.ROM_END(64000)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_fault(resp_fault), .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_write(mem_write), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Word memory with one cycle of read latency.
    always @(posedge clk) begin
        if (mem_write) mem[mem_address[17:2]] <= mem_data_in;
        mem_data_out <= mem[mem_address[17:2]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (mem_write) wr_cnt++;
        if (mem_address != 32'h0) anz_cnt++;
        if (!reset && resp_valid) begin
            resp_cyc.push_back(cyc);
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_resp: got rdata=%h fault=%b with nothing expected", resp_rdata, resp_fault);
            end else begin
                exp_t e;
                e = expq.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_fault", {31'b0, resp_fault}, {31'b0, e.fault});
                chk("resp_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_f,
                         input int lat, input logic keep);
        int n;
        @(negedge clk);
        req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: req_ready stayed %b, required 1", req_ready);
            req_valid = 1'b0;
            return;
        end
        expq.push_back('{rdata: exp_rd, fault: exp_f, cyc: cyc + lat});
        @(posedge clk);
        #1;
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (expq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", expq.size());
            expq.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int          wr0, anz0, n, base;
        logic [31:0] saved;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
        chk("rst_resp_fault", {31'b0, resp_fault}, 32'h0);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_data_in", mem_data_in, 32'h0);
        chk("rst_mem_write", {31'b0, mem_write}, 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_req_ready", {31'b0, req_ready}, 32'h1);

        // Word store then load back.
        issue(1, 2, 0, 32'h0001_0000, 32'hDEAD_BEEF, 32'h0, 0, 2, 0);
        issue(0, 2, 0, 32'h0001_0000, 32'h0,        32'hDEAD_BEEF, 0, 3, 0);
        drain();

        // Byte and halfword read-modify-write plus extending loads.
        issue(1, 2, 0, 32'h0001_0000, 32'h1122_3344, 32'h0, 0, 2, 0);
        issue(1, 0, 0, 32'h0001_0002, 32'h1234_56AA, 32'h0, 0, 4, 0);
        drain();
        chk("mem_after_byte_store", mem[16'h4000], 32'h11AA_3344);
        issue(0, 0, 1, 32'h0001_0002, 32'h0, 32'hFFFF_FFAA, 0, 3, 0);
        issue(0, 0, 0, 32'h0001_0002, 32'h0, 32'h0000_00AA, 0, 3, 0);
        issue(0, 1, 1, 32'h0001_0002, 32'h0, 32'h0000_11AA, 0, 3, 0);
        issue(1, 1, 0, 32'h0001_0000, 32'hFFFF_8001, 32'h0, 0, 4, 0);
        issue(0, 1, 1, 32'h0001_0000, 32'h0, 32'hFFFF_8001, 0, 3, 0);
        issue(0, 0, 0, 32'h0001_0003, 32'h0, 32'h0000_0011, 0, 3, 0);
        drain();
        chk("mem_after_half_store", mem[16'h4000], 32'h11AA_8001);

        // Faults: misalignment, reserved size, read-only region.
        wr0 = wr_cnt;
        anz0 = anz_cnt;
        issue(0, 1, 0, 32'h0001_0001, 32'h0, 32'h0, 1, 1, 0);
        issue(1, 2, 0, 32'h0000_0100, 32'h5555_5555, 32'h0, 1, 1, 0);
        issue(1, 0, 0, 32'd63999, 32'h0000_0077, 32'h0, 1, 1, 0);
        issue(1, 2, 0, 32'd63996, 32'h0000_0077, 32'h0, 1, 1, 0);
        issue(0, 3, 0, 32'h0001_0000, 32'h0, 32'h0, 1, 1, 0);
        issue(0, 2, 0, 32'h0001_0002, 32'h0, 32'h0, 1, 1, 0);
        drain();
        chk("fault_mem_write_cycles", wr_cnt, wr0);
        chk("fault_mem_address_cycles", anz_cnt, anz0);

        // First writable address.
        issue(1, 2, 0, 32'd64000, 32'hCAFE_F00D, 32'h0, 0, 2, 0);
        issue(0, 2, 0, 32'd64000, 32'h0, 32'hCAFE_F00D, 0, 3, 0);
        drain();

        // Reset during the WRITE of a byte store discards it.
        saved = mem[16'h4000];
        issue(1, 0, 0, 32'h0001_0000, 32'h0000_0055, 32'h0, 0, 4, 0);
        n = 0;
        while (!mem_write && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("reached_write", {31'b0, mem_write}, 32'h1);
        reset = 1'b1;
        expq.delete();
        #1;
        chk("reset_drops_mem_write", {31'b0, mem_write}, 32'h0);
        repeat (2) begin
            @(negedge clk);
            chk("reset_no_resp", {31'b0, resp_valid}, 32'h0);
        end
        reset = 1'b0;
        #1;
        chk("ready_after_release", {31'b0, req_ready}, 32'h1);
        repeat (5) @(negedge clk);
        chk("mem_unchanged_after_reset", mem[16'h4000], saved);

        // Continuous req_valid: one accept per IDLE, responses 4 cycles apart.
        resp_cyc.delete();
        issue(0, 2, 0, 32'h0001_0000, 32'h0, 32'h11AA_8001, 0, 3, 1);
        base = cyc - 1;
        issue(0, 2, 0, 32'd64000,     32'h0, 32'hCAFE_F00D, 0, 3, 1);
        issue(0, 2, 0, 32'h0001_0000, 32'h0, 32'h11AA_8001, 0, 3, 0);
        drain();
        chk("b2b_resp_count", resp_cyc.size(), 32'd3);
        if (resp_cyc.size() == 3) begin
            chk("b2b_first_resp", resp_cyc[0], base + 3);
            chk("b2b_spacing_1", resp_cyc[1] - resp_cyc[0], 32'd4);
            chk("b2b_spacing_2", resp_cyc[2] - resp_cyc[1], 32'd4);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
